// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StJal,
    StBeq
  } mc_state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Immediate format follows the opcode alone; R-type does not care and gets I.
  function automatic logic [1:0] imm_src_for(logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OpStore: imm = ImmS;
      OpBeq:   imm = ImmB;
      OpJal:   imm = ImmJ;
      default: imm = ImmI;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and status in, datapath selects and enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       illegal_instr;

  // Datapath side.
  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
    input  imm_src, alu_control, reg_write, illegal_instr
  );

  // Controller side.
  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
    output imm_src, alu_control, reg_write, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus instruction function bits onto the ALU operation select.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  // Only R-type (op[5]=1) with funct7b5 selects subtract; addi ignores bit 30.
  always_comb begin
    alu_control_o = AluAdd;
    unique case (alu_op_i)
      AluOpAdd: alu_control_o = AluAdd;
      AluOpSub: alu_control_o = AluSub;
      AluOpFunct: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluAdd;
        endcase
      end
      default: alu_control_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core; Moore outputs plus memory wait states.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.slave  bus
);

  mc_state_e state_q, state_d;
  alu_op_e   alu_op;
  logic      pc_update;
  logic      branch;
  logic      ready;

  // With waits disabled every memory access completes in its first cycle.
  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d           = state_q;
    alu_op            = AluOpAdd;
    pc_update         = 1'b0;
    branch            = 1'b0;
    bus.adr_src       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.result_src    = ResAluOut;
    bus.alu_src_a     = SrcAPc;
    bus.alu_src_b     = SrcBRd2;
    bus.reg_write     = 1'b0;
    bus.illegal_instr = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.alu_src_b  = SrcBFour;
        bus.result_src = ResAluResult;
        bus.ir_write   = ready;
        pc_update      = ready;
        state_d        = ready ? StDecode : StFetch;
      end
      StDecode: begin
        // Precompute the branch target while the opcode is decoded.
        bus.alu_src_a = SrcAOldPc;
        bus.alu_src_b = SrcBImm;
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default: begin
            bus.illegal_instr = 1'b1;
            state_d           = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = SrcARd1;
        bus.alu_src_b = SrcBImm;
        state_d       = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.adr_src = 1'b1;
        state_d     = ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        bus.result_src = ResData;
        bus.reg_write  = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = ready;
        state_d       = ready ? StFetch : StMemWrite;
      end
      StExecuteR: begin
        bus.alu_src_a = SrcARd1;
        alu_op        = AluOpFunct;
        state_d       = StAluWb;
      end
      StExecuteI: begin
        bus.alu_src_a = SrcARd1;
        bus.alu_src_b = SrcBImm;
        alu_op        = AluOpFunct;
        state_d       = StAluWb;
      end
      StAluWb: begin
        bus.reg_write = 1'b1;
        state_d       = StFetch;
      end
      StJal: begin
        // Link value PC+4 from OldPC; the jump target was formed in DECODE.
        bus.alu_src_a = SrcAOldPc;
        bus.alu_src_b = SrcBFour;
        pc_update     = 1'b1;
        state_d       = StAluWb;
      end
      StBeq: begin
        bus.alu_src_a = SrcARd1;
        alu_op        = AluOpSub;
        branch        = 1'b1;
        state_d       = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign bus.pc_write = pc_update | (branch & bus.zero);
  assign bus.imm_src  = imm_src_for(bus.op);

  multicycle_controller_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .op5_i         (bus.op[5]),
    .funct7b5_i    (bus.funct7b5),
    .alu_control_o (bus.alu_control)
  );

endmodule
